pc_shift_adder: RTL and testbench

- Branch-target adder for the LEGv8 datapath.
- Adds the current program counter to an already-shifted branch offset (produced upstream by the sign-extend and shift-left-2 stage) and produces the next-PC candidate.
- Unsigned arithmetic throughout.
- The result is registered with a valid flag and an overflow indication, and feeds the PC-source mux.

---
 rtl/pc_shift_adder.sv | 55 +++++
 tb/tb_pc_shift_adder.sv | 118 +++++++++++
 2 files changed

// File: rtl/pc_shift_adder.sv
// rtl/pc_shift_adder.sv - registered PC + shifted-offset branch-target adder with overflow flag
// Optional build macro: PCSA_SATURATE_EN (clamp the target to all-ones on overflow).
module pc_shift_adder #(
  parameter int PC_W  = 12,
  parameter int OFF_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] shifted_addr,
  output logic [PC_W-1:0]  out,
  output logic             out_valid,
  output logic             ovf
);

  logic [PC_W:0]   full;
  logic            upper_set;
  logic            ovf_next;
  logic [PC_W-1:0] out_next;

  // Offset bits above the PC width never reach the sum; they only flag overflow.
  generate
    if (OFF_W > PC_W) begin : g_upper
      assign upper_set = |shifted_addr[OFF_W-1:PC_W];
    end else begin : g_no_upper
      assign upper_set = 1'b0;
    end
  endgenerate

  always_comb begin
    full     = {1'b0, pc} + {1'b0, shifted_addr[PC_W-1:0]};
    ovf_next = full[PC_W] | upper_set;
`ifdef PCSA_SATURATE_EN
    out_next = ovf_next ? {PC_W{1'b1}} : full[PC_W-1:0];
`else
    out_next = full[PC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= out_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_pc_shift_adder.sv
// tb/tb_pc_shift_adder.sv - directed self-checking bench for pc_shift_adder
module tb_pc_shift_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] pc;
  logic [63:0] shifted_addr;
  logic [11:0] out;
  logic        out_valid;
  logic        ovf;

  int total = 0;
  int bad   = 0;

`ifdef PCSA_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  pc_shift_adder #(.PC_W(12), .OFF_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .pc           (pc),
    .shifted_addr (shifted_addr),
    .out          (out),
    .out_valid    (out_valid),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] e_out, input logic e_ovf, input logic e_vld);
    check({tag, ".out"}, {52'd0, out}, {52'd0, e_out});
    check({tag, ".ovf"}, {63'd0, ovf}, {63'd0, e_ovf});
    check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, e_vld});
  endtask

  // Drive operands, then sample 1ns after the capturing edge.
  task automatic step(input logic v, input logic [11:0] p, input logic [63:0] o);
    in_valid     = v;
    pc           = p;
    shifted_addr = o;
    @(posedge clk);
    #1;
  endtask

  int offs [7] = '{8, 50, 7, 9, 76, 100, 27};

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; pc = '0; shifted_addr = '0;

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1 check_all("reset_async", 12'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step(1'b0, 12'd77, 64'd5);
    step(1'b0, 12'd77, 64'd5);
    check_all("post_reset_idle", 12'd0, 1'b0, 1'b0);

    // Back-to-back nominal sweep, pc=300
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 12'd300, 64'(offs[i]));
      check_all($sformatf("sweep%0d", i), 12'(300 + offs[i]), 1'b0, 1'b1);
    end

    // Boundaries
    step(1'b1, 12'd0, 64'd0);
    check_all("zero_zero", 12'd0, 1'b0, 1'b1);
    step(1'b1, 12'd4095, 64'd1);
    check_all("wrap_max", SAT ? 12'd4095 : 12'd0, 1'b1, 1'b1);
    step(1'b1, 12'd1234, 64'd0);
    check_all("pass_through", 12'd1234, 1'b0, 1'b1);

    // Carry overflow and upper-bit overflow
    step(1'b1, 12'd4090, 64'd10);
    check_all("carry_ovf", SAT ? 12'd4095 : 12'd4, 1'b1, 1'b1);
    step(1'b1, 12'd5, 64'h1000_0000_0000_0001);
    check_all("upper_ovf", SAT ? 12'd4095 : 12'd6, 1'b1, 1'b1);

    // Hold on in_valid=0
    step(1'b1, 12'd300, 64'd100);
    check_all("hold_load", 12'd400, 1'b0, 1'b1);
    step(1'b0, 12'd1, 64'd1);
    check_all("hold_idle", 12'd400, 1'b0, 1'b0);

    // Overflow flag also held across an idle cycle
    step(1'b1, 12'd4090, 64'd10);
    step(1'b0, 12'd0, 64'd0);
    check_all("hold_ovf", SAT ? 12'd4095 : 12'd4, 1'b1, 1'b0);

    // Mid-stream reset pulse with valid operands still presented
    step(1'b1, 12'd300, 64'd50);
    check_all("stream_pre", 12'd350, 1'b0, 1'b1);
    in_valid = 1'b1; pc = 12'd300; shifted_addr = 64'd76;
    rst_n = 1'b0;
    #1 check_all("midreset_async", 12'd0, 1'b0, 1'b0);
    #4 rst_n = 1'b1;
    step(1'b1, 12'd300, 64'd27);
    check_all("after_midreset", 12'd327, 1'b0, 1'b1);
    step(1'b0, 12'd0, 64'd0);
    check_all("after_midreset_idle", 12'd327, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
